vram_arbiter: RTL and testbench

- Shares one single-port synchronous framebuffer RAM between the VGA pixel fetch path and one host (CPU/drawing engine) port.
- Video fetch has absolute priority, using reserved slots derived from the sync generator's x/y/blank; the host uses every other cycle.
- Sits between vga_sync (timing), the framebuffer RAM and the host bus, and produces the registered pixel stream for the DAC.

---
 rtl/vram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port framebuffer RAM between the video fetch path and a host port.
// Define VRAM_ARB_STATS_EN to add the stall_cnt output (host cycles deferred by video slots).
module vram_arbiter #(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PIX_W    = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              blank,
    output logic [PIX_W-1:0]  pix,
    output logic              blank_d,
    input  logic              host_req,
    output logic              host_gnt,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned WPL = H_ACTIVE / 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PEND   = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic              r_vs_d;
    logic [DATA_W-1:0] r_nxt_word;
    logic [DATA_W-1:0] r_cur_word;
    logic [PIX_W-1:0]  r_pix;
    logic              r_blank_d;

    logic [7:0]        w_word_n;
    logic              w_vs;
    logic [ADDR_W-1:0] w_vid_addr;
    logic [PIX_W-1:0]  w_pix;

    // Slot at x=4n-4 fetches word n; x[9:2]+1 is that word index modulo 256.
    assign w_word_n   = x[9:2] + 8'd1;
    assign w_vs       = (x[1:0] == 2'b00)
                      && ({1'b0, w_word_n} < 9'(WPL))
                      && ({1'b0, y} < 11'(V_ACTIVE));
    assign w_vid_addr = ADDR_W'(y) * ADDR_W'(WPL) + ADDR_W'(w_word_n);

    // RAM port: video slot wins, otherwise a pending host op is issued.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!RST) begin
            if (w_vs) begin
                mem_en   = 1'b1;
                mem_addr = w_vid_addr;
            end else if (r_state == S_PEND) begin
                mem_en   = 1'b1;
                mem_we   = r_we;
                mem_addr = r_addr;
                if (r_we) begin
                    mem_wdata = r_wdata;
                end
            end
        end
    end

    // Host FSM; grant mirrors the IDLE state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_gnt    <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (host_req) begin
                        r_we    <= host_we;
                        r_addr  <= host_addr;
                        r_wdata <= host_wdata;
                        r_gnt   <= 1'b0;
                        r_state <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (!w_vs) begin
                        if (r_we) begin
                            r_state <= S_IDLE;
                            r_gnt   <= 1'b1;
                        end else begin
                            r_state <= S_RDWAIT;
                        end
                    end
                end
                S_RDWAIT: begin
                    r_rdata  <= mem_rdata;
                    r_rvalid <= 1'b1;
                    r_state  <= S_IDLE;
                    r_gnt    <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_pix = r_cur_word[PIX_W-1:0];
        case (x[1:0])
            2'd1:    w_pix = r_cur_word[PIX_W +: PIX_W];
            2'd2:    w_pix = r_cur_word[2*PIX_W +: PIX_W];
            2'd3:    w_pix = r_cur_word[3*PIX_W +: PIX_W];
            default: w_pix = r_cur_word[PIX_W-1:0];
        endcase
    end

    // Video pipe: fetched word lands in nxt, moves to cur at the word boundary.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vs_d     <= 1'b0;
            r_nxt_word <= '0;
            r_cur_word <= '0;
            r_pix      <= '0;
            r_blank_d  <= 1'b1;
        end else begin
            r_vs_d    <= w_vs;
            r_pix     <= w_pix;
            r_blank_d <= blank;
            if (r_vs_d) begin
                r_nxt_word <= mem_rdata;
            end
            if (x[1:0] == 2'b11) begin
                r_cur_word <= r_nxt_word;
            end
        end
    end

    assign pix         = r_pix;
    assign blank_d     = r_blank_d;
    assign host_gnt    = r_gnt;
    assign host_rdata  = r_rdata;
    assign host_rvalid = r_rvalid;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall_clr;

    assign w_stall_clr = host_req && r_gnt && host_we && (host_addr == {ADDR_W{1'b1}});

    // Counts cycles a pending host op loses to a video slot; saturates.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall_clr) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_PEND) && w_vs && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed table, hand sequences and a randomized raster run.
module tb_vram_arbiter;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PIX_W  = 4;

    logic              CLK;
    logic              RST;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              blank;
    logic [PIX_W-1:0]  pix;
    logic              blank_d;
    logic              host_req;
    logic              host_gnt;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]       stall_cnt;
`endif

    vram_arbiter dut (
        .CLK         (CLK),
        .RST         (RST),
        .x           (x),
        .y           (y),
        .blank       (blank),
        .pix         (pix),
        .blank_d     (blank_d),
        .host_req    (host_req),
        .host_gnt    (host_gnt),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
        , .stall_cnt (stall_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM environment: unwritten words read back as addr[15:0].
    logic [15:0] ram [int];
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) ram[int'(mem_addr)] = mem_wdata;
            else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : mem_addr[15:0];
        end
    end

    // Reference memory contents as seen by the host-level model.
    logic [15:0] shadow [int];
    function automatic logic [15:0] exp_word(input int a);
        return shadow.exists(a) ? shadow[a] : 16'(a);
    endfunction

    function automatic bit vs_of(input int xx, input int yy);
        return ((xx % 4) == 0) && (((xx + 4) % 1024) < 640) && (yy < 480);
    endfunction

    function automatic int vaddr_of(input int xx, input int yy);
        return yy * 160 + ((xx + 4) % 1024) / 4;
    endfunction

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic go(input int nx, input int ny, input logic req, input logic we,
                      input int addr, input logic [15:0] wd);
        @(posedge CLK);
        #1;
        x          = 10'(nx);
        y          = 10'(ny);
        blank      = !((nx < 640) && (ny < 480));
        host_req   = req;
        host_we    = we;
        host_addr  = ADDR_W'(addr);
        host_wdata = wd;
        #1;
    endtask

    typedef struct {
        int   vx;
        int   vy;
        logic exp_en;
        int   exp_addr;
    } vec_t;

    vec_t tbl [12];
    logic [3:0] px [4];
    int ylist [8];

    initial begin
        int n_g, n_w, n_r, xi, nx, cyc;
        bit m_pend, m_we, evs, egnt, was_pend;
        int m_addr, m_cap, m_rv, m_rdwait;
        logic [15:0] m_wd, m_rv_data;
        int prev_x, prev_y, ra;
        logic prev_blank, rq, rw;
        logic [15:0] rd;
`ifdef VRAM_ARB_STATS_EN
        int m_stall;
`endif

        RST = 1'b1; x = 10'd1020; y = 10'd2; blank = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

        // Reset state, with the slot inputs pointing at a video fetch.
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_pix", 32'(pix), 32'd0);
        chk("rst_blank_d", 32'(blank_d), 32'd1);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        chk("rst_gnt", 32'(host_gnt), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;

        // Slot decode and video address table (host idle).
        tbl[0]  = '{1020, 2,   1'b1, 320};
        tbl[1]  = '{632,  2,   1'b1, 479};
        tbl[2]  = '{0,    0,   1'b1, 1};
        tbl[3]  = '{636,  0,   1'b0, 0};
        tbl[4]  = '{1,    0,   1'b0, 0};
        tbl[5]  = '{1020, 479, 1'b1, 76640};
        tbl[6]  = '{632,  479, 1'b1, 76799};
        tbl[7]  = '{0,    480, 1'b0, 0};
        tbl[8]  = '{1016, 0,   1'b0, 0};
        tbl[9]  = '{640,  5,   1'b0, 0};
        tbl[10] = '{628,  3,   1'b1, 638};
        tbl[11] = '{4,    1,   1'b1, 162};
        for (int i = 0; i < 12; i++) begin
            go(tbl[i].vx, tbl[i].vy, 1'b0, 1'b0, 0, 16'h0);
            chk($sformatf("tbl%0d_en", i), 32'(mem_en), 32'(tbl[i].exp_en));
            chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'd0);
            chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].exp_addr));
        end

        // Line y=2: word 0x0140 shown at x=0..3, each one cycle late.
        px[0] = 4'h0; px[1] = 4'h4; px[2] = 4'h1; px[3] = 4'h0;
        for (int i = 0; i < 8 + 641; i++) begin
            xi = (1016 + i) % 1024;
            go(xi, 2, 1'b0, 1'b0, 0, 16'h0);
            if (xi == 1020) chk("y2_addr_1020", 32'(mem_addr), 32'd320);
            if (xi == 632) chk("y2_addr_632", 32'(mem_addr), 32'd479);
            if (xi >= 1 && xi <= 4) begin
                chk($sformatf("y2_pix_x%0d", xi - 1), 32'(pix), 32'(px[xi-1]));
                chk("y2_blank_d", 32'(blank_d), 32'd0);
            end
        end

        // Host write arriving in a video slot.
        go(1019, 0, 1'b0, 1'b0, 0, 16'h0);
        go(1020, 0, 1'b1, 1'b1, 5, 16'hBEEF);
        chk("wr_gnt_in_vs", 32'(host_gnt), 32'd1);
        chk("wr_vs_addr", 32'(mem_addr), 32'd0);
        go(1021, 0, 1'b0, 1'b0, 0, 16'h0);
        chk("wr_issue_we", 32'(mem_we), 32'd1);
        chk("wr_issue_addr", 32'(mem_addr), 32'd5);
        chk("wr_issue_data", 32'(mem_wdata), 32'hBEEF);
        go(1022, 0, 1'b0, 1'b0, 0, 16'h0);
        chk("wr_back_idle", 32'(host_gnt), 32'd1);
        chk("wr_no_mem", 32'(mem_en), 32'd0);
        shadow[5] = 16'hBEEF;

        // Host read captured just before a video slot.
        go(3, 10, 1'b1, 1'b0, 5, 16'h0);
        chk("rd_gnt", 32'(host_gnt), 32'd1);
        go(4, 10, 1'b0, 1'b0, 0, 16'h0);
        chk("rd_defer_addr", 32'(mem_addr), 32'd1602);
        chk("rd_defer_we", 32'(mem_we), 32'd0);
        go(5, 10, 1'b0, 1'b0, 0, 16'h0);
        chk("rd_issue_en", 32'(mem_en), 32'd1);
        chk("rd_issue_addr", 32'(mem_addr), 32'd5);
        go(6, 10, 1'b0, 1'b0, 0, 16'h0);
        chk("rd_wait_rvalid", 32'(host_rvalid), 32'd0);
        chk("rd_wait_gnt", 32'(host_gnt), 32'd0);
        go(7, 10, 1'b0, 1'b0, 0, 16'h0);
        chk("rd_rvalid", 32'(host_rvalid), 32'd1);
        chk("rd_rdata", 32'(host_rdata), 32'hBEEF);
        go(8, 10, 1'b0, 1'b0, 0, 16'h0);
        chk("rd_rvalid_pulse", 32'(host_rvalid), 32'd0);

        // Reset while a read is pending: op dropped.
        go(3, 10, 1'b1, 1'b0, 32'h100, 16'h0);
        go(4, 10, 1'b0, 1'b0, 0, 16'h0);
        RST = 1'b1;
        #1;
        chk("rstp_mem_en", 32'(mem_en), 32'd0);
        go(5, 10, 1'b0, 1'b0, 0, 16'h0);
        chk("rstp_mem_en2", 32'(mem_en), 32'd0);
        go(6, 10, 1'b0, 1'b0, 0, 16'h0);
        RST = 1'b0;
        #1;
        chk("rstp_gnt", 32'(host_gnt), 32'd1);
        chk("rstp_mem_en3", 32'(mem_en), 32'd0);
        for (int i = 7; i < 12; i++) begin
            go(i, 10, 1'b0, 1'b0, 0, 16'h0);
            chk("rstp_rvalid", 32'(host_rvalid), 32'd0);
            if (i == 8) chk("rstp_vs_addr", 32'(mem_addr), 32'd1603);
            else chk("rstp_no_issue", 32'(mem_en), 32'd0);
        end

        // Back-to-back writes during vertical blanking.
        n_g = 0; n_w = 0; n_r = 0;
        for (int i = 0; i < 1000; i++) begin
            go(i % 800, 500, 1'b1, 1'b1, 90000 + i, 16'(i * 3));
            if (host_req && host_gnt) n_g++;
            if (mem_en && mem_we) begin
                n_w++;
                chk("b2b_addr", 32'(mem_addr), 32'(90000 + i - 1));
            end
            if (mem_en && !mem_we) n_r++;
            if ((i % 2) == 0) shadow[90000 + i] = 16'(i * 3);
        end
        chk("b2b_grants", 32'(n_g), 32'd500);
        chk("b2b_writes", 32'(n_w), 32'd500);
        chk("b2b_vs_reads", 32'(n_r), 32'd0);
        go(0, 500, 1'b0, 1'b0, 0, 16'h0);
        go(1, 500, 1'b0, 1'b0, 0, 16'h0);

`ifdef VRAM_ARB_STATS_EN
        // Ten ops each deferred once, then the clearing write.
        go(700, 10, 1'b0, 1'b0, 0, 16'h0);
        RST = 1'b1; #1; RST = 1'b0; #1;
        for (int i = 0; i < 10; i++) begin
            go(3, 10, 1'b1, 1'b1, 32'h1F000 + i, 16'(i));
            shadow[32'h1F000 + i] = 16'(i);
            go(4, 10, 1'b0, 1'b0, 0, 16'h0);
            go(5, 10, 1'b0, 1'b0, 0, 16'h0);
            go(6, 10, 1'b0, 1'b0, 0, 16'h0);
        end
        chk("stat_cnt10", 32'(stall_cnt), 32'd10);
        go(700, 10, 1'b1, 1'b1, 32'h1FFFF, 16'hAAAA);
        chk("stat_pre_clr", 32'(stall_cnt), 32'd10);
        go(701, 10, 1'b0, 1'b0, 0, 16'h0);
        chk("stat_clr", 32'(stall_cnt), 32'd0);
        chk("stat_clr_write", 32'(mem_addr), 32'h1FFFF);
        shadow[32'h1FFFF] = 16'hAAAA;
        go(702, 10, 1'b0, 1'b0, 0, 16'h0);
`endif

        // Randomized raster run against the host-level model.
        go(800, 600, 1'b0, 1'b0, 0, 16'h0);
        RST = 1'b1; #1; RST = 1'b0; #1;
        ylist[0] = 0; ylist[1] = 1; ylist[2] = 2; ylist[3] = 239;
        ylist[4] = 478; ylist[5] = 479; ylist[6] = 480; ylist[7] = 600;
        m_pend = 1'b0; m_we = 1'b0; m_addr = 0; m_wd = '0; m_cap = 0;
        m_rv = -100; m_rdwait = -100; m_rv_data = '0;
        prev_x = 800; prev_y = 600; prev_blank = 1'b1; cyc = 0;
`ifdef VRAM_ARB_STATS_EN
        m_stall = 0;
`endif
        for (int l = 0; l < 8; l++) begin
            for (int j = 0; j < 804; j++) begin
                nx = (j < 4) ? (1020 + j) : (j - 4);
                rq = ($urandom_range(0, 99) < 60);
                rw = 1'($urandom_range(0, 1));
                ra = rw ? (76800 + int'($urandom_range(0, 131071 - 76800)))
                        : int'($urandom_range(0, 131071));
                rd = 16'($urandom);
                go(nx, ylist[l], rq, rw, ra, rd);
                evs = vs_of(nx, ylist[l]);
                egnt = !m_pend && (cyc != m_rdwait);
                was_pend = m_pend;
                chk("rnd_gnt", 32'(host_gnt), 32'(egnt));
                chk("rnd_rvalid", 32'(host_rvalid), 32'(cyc == m_rv));
                if (cyc == m_rv) chk("rnd_rdata", 32'(host_rdata), 32'(m_rv_data));
                chk("rnd_blank_d", 32'(blank_d), 32'(prev_blank));
                if (prev_x < 640 && prev_y < 480)
                    chk("rnd_pix", 32'(pix),
                        32'((exp_word(prev_y * 160 + prev_x / 4) >> (4 * (prev_x % 4))) & 16'hF));
                if (evs) begin
                    chk("rnd_vs_en", 32'(mem_en), 32'd1);
                    chk("rnd_vs_we", 32'(mem_we), 32'd0);
                    chk("rnd_vs_addr", 32'(mem_addr), 32'(vaddr_of(nx, ylist[l])));
                end else if (m_pend) begin
                    chk("rnd_host_en", 32'(mem_en), 32'd1);
                    chk("rnd_host_we", 32'(mem_we), 32'(m_we));
                    chk("rnd_host_addr", 32'(mem_addr), 32'(m_addr));
                    chk("rnd_host_lat", 32'((cyc - m_cap) <= 2), 32'd1);
                    if (m_we) begin
                        chk("rnd_host_wdata", 32'(mem_wdata), 32'(m_wd));
                        shadow[m_addr] = m_wd;
                    end else begin
                        m_rv = cyc + 2;
                        m_rdwait = cyc + 1;
                        m_rv_data = exp_word(m_addr);
                    end
                    m_pend = 1'b0;
                end else begin
                    chk("rnd_idle_en", 32'(mem_en), 32'd0);
                end
`ifdef VRAM_ARB_STATS_EN
                chk("rnd_stall", 32'(stall_cnt), 32'(m_stall));
                if (rq && egnt && rw && ra == 131071) m_stall = 0;
                else if (was_pend && evs && m_stall < 65535) m_stall++;
`endif
                if (rq && egnt) begin
                    m_pend = 1'b1;
                    m_we = rw;
                    m_addr = ra;
                    m_wd = rd;
                    m_cap = cyc;
                end
                prev_x = nx;
                prev_y = ylist[l];
                prev_blank = blank;
                cyc++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
